gaussian_conv_1d: RTL and testbench
===================================

GAUSSIAN_CONV_1D -- requirements
Module: gaussian_conv_1d

Interface
REQ-001 Parameter IMAGE_COLUMN, default 512, pixels per image line.
REQ-002 Parameter DATA_WIDTH, default 8, unsigned pixel width.
REQ-003 Parameter PAD, default 5, kernel half-width; TAPS = 2*PAD+1 = 11.
REQ-004 Parameter COEF_WIDTH, default 16, unsigned coefficient width.
REQ-005 Parameter COEF_FRAC, default 14, fractional bits of coefficients; COEF_FRAC >= 1.
REQ-006 Single clock `clk`; reset `rst_n` synchronous, active-low; all state updates on posedge clk.
REQ-007 clk  input  1  clock.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 valid_in  input  1  window valid; low between lines.
REQ-010 data_in  input  [TAPS-1:0][DATA_WIDTH-1:0]  pixel window, element PAD is the centre.
REQ-011 coef_load  input  1  one-cycle request to capture coef_in.
REQ-012 coef_in  input  [PAD:0][COEF_WIDTH-1:0]  symmetric half-kernel, element 0 = centre tap.
REQ-013 valid_out  output  1  filtered pixel valid.
REQ-014 data_out  output  [DATA_WIDTH-1:0]  filtered, rounded, saturated pixel.
REQ-015 eol_out  output  1  high with the last valid_out of a line.
REQ-016 border_out  output  1  high when the output column is < PAD or > IMAGE_COLUMN-1-PAD.
REQ-017 coef_busy  output  1  shadow coefficients pending, not yet active.

Function
REQ-018 Stage 1 SHALL pre-add symmetric pairs: s[k] = data_in[PAD+k] + data_in[PAD-k] for k=1..PAD (DATA_WIDTH+1 bits); s[0] = data_in[PAD].
REQ-019 Stage 2 SHALL register products p[k] = s[k] * active_coef[k], full width, no truncation.
REQ-020 Stages 3..2+T, T = ceil(log2(PAD+1)), SHALL form a registered binary adder tree of p[0..PAD], full width (3 stages for PAD=5).
REQ-021 Final stage SHALL add 2^(COEF_FRAC-1), shift right by COEF_FRAC, and saturate to 2^DATA_WIDTH-1.
REQ-022 Latency valid_in -> valid_out SHALL be LATENCY = 3+T cycles (6 by default), fixed, with no stalls and no back-pressure.
REQ-023 valid SHALL propagate through a LATENCY-deep shift register independent of data; data_out SHALL be 0 when valid_out is low.
REQ-024 Output column counter SHALL increment on each valid_out, wrap IMAGE_COLUMN-1 -> 0, and clear to 0 on any cycle valid_out is low.
REQ-025 eol_out = valid_out AND column == IMAGE_COLUMN-1; border_out = valid_out AND border condition of REQ-016.
REQ-026 coef_load SHALL capture coef_in into a shadow register and set coef_busy; a later coef_load while busy overwrites the shadow.
REQ-027 Shadow SHALL copy to active and coef_busy clear on the first cycle with valid_in low AND no valid in any pipeline stage; the copy never occurs mid-line.
REQ-028 If coef_load and the copy condition coincide, the new coef_in SHALL go to shadow and the copy SHALL use coef_in directly (busy ends clear).
REQ-029 valid_in dropping mid-line SHALL flush normally; already-accepted windows still emit and the column counter restarts at 0.

Reset
REQ-030 While rst_n=0: valid_out, data_out, eol_out, border_out, coef_busy = 0; pipeline valids and column counter = 0.
REQ-031 Reset SHALL load active coefficients with the identity kernel: coef[0] = 2^COEF_FRAC, others 0; shadow also identity.
REQ-032 Reset asserted mid-line SHALL discard all in-flight data; first valid_out after release occurs LATENCY cycles after the next valid_in.

Verification
REQ-033 After reset, constant window of 100 for 512 cycles -> 512 outputs of 100 after 6 cycles, eol_out on the 512th only, border_out on columns 0-4 and 507-511.
REQ-034 Load coef {8192,4096,0,0,0,0} (sum 16384), window centre 200, neighbours +/-1 = 100, others 0 -> data_out = 150.
REQ-035 All taps 255, all coefs 16383 -> data_out saturates to 255, no wrap.
REQ-036 coef_load at column 100 of a line -> coef_busy high, old kernel used through column 511, new kernel first at the next line, coef_busy clears in the gap.
REQ-037 Drop valid_in at column 300 for 3 cycles, then resume -> 300 outputs, then counter restarts at 0, eol_out after 512 further outputs.
REQ-038 Pull rst_n low for 1 cycle mid-line -> all outputs 0 next cycle, active kernel back to identity (output = centre pixel).

Source files
------------

// File: rtl/gaussian_conv_1d_if.sv
// Bundle of the stream, coefficient-load and status signals of gaussian_conv_1d.
//   valid_in / data_in   : pixel window, element PAD is the centre pixel
//   coef_load / coef_in  : one-cycle capture of a symmetric half-kernel, element 0 = centre tap
//   valid_out / data_out : filtered pixel, zero when not valid
//   eol_out / border_out : last pixel of a line / pixel within PAD of either line end
//   coef_busy            : shadow kernel captured but not yet active
// master drives the inputs (source side), slave is the filter.
interface gaussian_conv_1d_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PAD        = 5,
  parameter int unsigned COEF_WIDTH = 16
);
  localparam int unsigned TAPS = 2 * PAD + 1;

  logic                                 valid_in;
  logic [TAPS-1:0][DATA_WIDTH-1:0]      data_in;
  logic                                 coef_load;
  logic [PAD:0][COEF_WIDTH-1:0]         coef_in;
  logic                                 valid_out;
  logic [DATA_WIDTH-1:0]                data_out;
  logic                                 eol_out;
  logic                                 border_out;
  logic                                 coef_busy;

  modport master (
    output valid_in, data_in, coef_load, coef_in,
    input  valid_out, data_out, eol_out, border_out, coef_busy
  );

  modport slave (
    input  valid_in, data_in, coef_load, coef_in,
    output valid_out, data_out, eol_out, border_out, coef_busy
  );
endinterface

// File: rtl/gaussian_conv_1d.sv
// Symmetric 1-D FIR (Gaussian) filter over a pre-assembled pixel window.
// Pipeline: pre-add symmetric pairs -> multiply by active kernel -> registered
// binary adder tree -> round, shift, saturate. Fixed latency 3 + ceil(log2(PAD+1)).
// Ports:
//   clk   : clock, all state on its rising edge
//   rst_n : synchronous active-low reset
//   bus   : gaussian_conv_1d_if slave (window in, filtered pixel out, kernel load)
// Kernel updates go through a shadow register and are only promoted when the
// whole pipeline is empty, so a line is always filtered with a single kernel.
// Requires PAD >= 1 and COEF_WIDTH > COEF_FRAC >= 1.
module gaussian_conv_1d #(
  parameter int unsigned IMAGE_COLUMN = 512,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned PAD          = 5,
  parameter int unsigned COEF_WIDTH   = 16,
  parameter int unsigned COEF_FRAC    = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gaussian_conv_1d_if.slave     bus
);
  localparam int unsigned T       = $clog2(PAD + 1);
  localparam int unsigned LATENCY = 3 + T;
  localparam int unsigned NP2     = 1 << T;            // adder-tree leaves, zero padded
  localparam int unsigned SW      = DATA_WIDTH + 1;    // pre-added pair
  localparam int unsigned PW      = SW + COEF_WIDTH;   // product
  localparam int unsigned TW      = PW + T;            // tree sum
  localparam int unsigned CW      = $clog2(IMAGE_COLUMN);

  localparam logic [COEF_WIDTH-1:0]        CoefOne   = COEF_WIDTH'(1) << COEF_FRAC;
  localparam logic [PAD:0][COEF_WIDTH-1:0] CoefIdent = {{(PAD * COEF_WIDTH){1'b0}}, CoefOne};
  localparam logic [TW:0]                  Half      = (TW + 1)'(1) << (COEF_FRAC - 1);
  localparam logic [CW-1:0]                LastCol   = CW'(IMAGE_COLUMN - 1);
  localparam logic [CW-1:0]                LeftEdge  = CW'(PAD);
  localparam logic [CW-1:0]                RightEdge = CW'(IMAGE_COLUMN - 1 - PAD);

  logic [PAD:0][SW-1:0]         sum_d, sum_q;
  logic [PAD:0][PW-1:0]         prod_d, prod_q;
  logic [TW-1:0]                node_d [1:NP2-1];
  logic [TW-1:0]                node_q [1:NP2-1];
  logic [TW-1:0]                all_nodes [1:2*NP2-1];
  logic [TW:0]                  rnd, shf;
  logic [DATA_WIDTH-1:0]        sat;
  logic [DATA_WIDTH-1:0]        data_out_d, data_out_q;
  logic [LATENCY-1:0]           valid_d, valid_q;
  logic [CW-1:0]                col_d, col_q;
  logic [PAD:0][COEF_WIDTH-1:0] shadow_d, shadow_q, active_d, active_q;
  logic                         busy_d, busy_q;
  logic                         pipe_idle;
  logic                         valid_out;

  // Datapath
  always_comb begin
    sum_d[0] = SW'(bus.data_in[PAD]);
    for (int unsigned k = 1; k <= PAD; k++) begin
      sum_d[k] = SW'(bus.data_in[PAD+k]) + SW'(bus.data_in[PAD-k]);
    end
    for (int unsigned k = 0; k <= PAD; k++) begin
      prod_d[k] = PW'(sum_q[k]) * PW'(active_q[k]);
    end
    // Heap layout: node i sums nodes 2i and 2i+1; leaves sit at NP2..2*NP2-1.
    for (int unsigned i = 1; i < 2 * NP2; i++) all_nodes[i] = '0;
    for (int unsigned i = 1; i < NP2; i++) all_nodes[i] = node_q[i];
    for (int unsigned k = 0; k <= PAD; k++) all_nodes[NP2+k] = TW'(prod_q[k]);
    for (int unsigned i = 1; i < NP2; i++) begin
      node_d[i] = all_nodes[2*i] + all_nodes[2*i+1];
    end
    rnd = {1'b0, node_q[1]} + Half;
    shf = rnd >> COEF_FRAC;
    sat = (|shf[TW:DATA_WIDTH]) ? '1 : shf[DATA_WIDTH-1:0];
    data_out_d = valid_q[LATENCY-2] ? sat : '0;
  end

  // Control: valid pipe, column counter, kernel shadow/active
  always_comb begin
    valid_d   = {valid_q[LATENCY-2:0], bus.valid_in};
    valid_out = valid_q[LATENCY-1];
    col_d     = '0;
    if (valid_out) col_d = (col_q == LastCol) ? '0 : col_q + 1'b1;

    pipe_idle = !bus.valid_in && !(|valid_q);
    shadow_d  = bus.coef_load ? bus.coef_in : shadow_q;
    active_d  = active_q;
    busy_d    = busy_q | bus.coef_load;
    if (pipe_idle) begin
      // A load arriving on the promotion cycle bypasses the shadow.
      active_d = bus.coef_load ? bus.coef_in : shadow_q;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= '0;
      col_q      <= '0;
      data_out_q <= '0;
      busy_q     <= 1'b0;
      shadow_q   <= CoefIdent;
      active_q   <= CoefIdent;
    end else begin
      valid_q    <= valid_d;
      col_q      <= col_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  // Data registers need no reset: the valid pipe qualifies everything.
  always_ff @(posedge clk) begin
    sum_q  <= sum_d;
    prod_q <= prod_d;
    node_q <= node_d;
  end

  assign bus.valid_out  = valid_out;
  assign bus.data_out   = data_out_q;
  assign bus.eol_out    = valid_out && (col_q == LastCol);
  assign bus.border_out = valid_out && ((col_q < LeftEdge) || (col_q > RightEdge));
  assign bus.coef_busy  = busy_q;
endmodule

// File: tb/tb_gaussian_conv_1d.sv
module tb_gaussian_conv_1d;
  localparam int unsigned IC   = 512;
  localparam int unsigned DW   = 8;
  localparam int unsigned PAD  = 5;
  localparam int unsigned CWD  = 16;
  localparam int unsigned CF   = 14;
  localparam int unsigned TAPS = 2 * PAD + 1;
  localparam int unsigned LAT  = 6;

  typedef logic [TAPS-1:0][DW-1:0] win_t;
  typedef logic [PAD:0][CWD-1:0]   coef_t;
  typedef struct {
    string      name;
    win_t       win;
    coef_t      coef;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gaussian_conv_1d_if #(.DATA_WIDTH(DW), .PAD(PAD), .COEF_WIDTH(CWD)) bus ();

  gaussian_conv_1d #(
    .IMAGE_COLUMN(IC),
    .DATA_WIDTH  (DW),
    .PAD         (PAD),
    .COEF_WIDTH  (CWD),
    .COEF_FRAC   (CF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: expected pixel travels with valid through a LAT-deep delay line.
  logic [DW-1:0]  exp_pix;
  logic [LAT-1:0] m_v;
  logic [DW-1:0]  m_d [LAT];
  int             m_col;
  logic           mon_en = 1'b0;
  int             out_cnt, eol_cnt, border_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_v   <= '0;
      m_col <= 0;
    end else begin
      m_v <= {m_v[LAT-2:0], bus.valid_in};
      for (int i = LAT - 1; i > 0; i--) m_d[i] <= m_d[i-1];
      m_d[0] <= exp_pix;
      m_col  <= m_v[LAT-1] ? ((m_col == IC - 1) ? 0 : m_col + 1) : 0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon valid_out", 32'(bus.valid_out), 32'(m_v[LAT-1]));
      check("mon data_out", 32'(bus.data_out), m_v[LAT-1] ? 32'(m_d[LAT-1]) : 32'd0);
      check("mon eol_out", 32'(bus.eol_out), 32'(m_v[LAT-1] && (m_col == IC - 1)));
      check("mon border_out", 32'(bus.border_out),
            32'(m_v[LAT-1] && ((m_col < PAD) || (m_col > IC - 1 - PAD))));
      if (bus.valid_out)  out_cnt++;
      if (bus.eol_out)    eol_cnt++;
      if (bus.border_out) border_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.coef_load = 1'b0;
    bus.coef_in   = '0;
    exp_pix       = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_coef(input coef_t c);
    bus.coef_in   = c;
    bus.coef_load = 1'b1;
    tick();
    bus.coef_load = 1'b0;
  endtask

  task automatic clear_tally();
    out_cnt    = 0;
    eol_cnt    = 0;
    border_cnt = 0;
  endtask

  function automatic win_t mkwin(input logic [7:0] c, input logic [7:0] n1);
    win_t w;
    w    = '0;
    w[5] = c;
    w[4] = n1;
    w[6] = n1;
    return w;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t  vecs [9];
  coef_t k_id, k1, k_half;
  logic [7:0] c8;

  initial begin
    k_id      = '0;
    k_id[0]   = 16'd16384;
    k1        = '0;
    k1[0]     = 16'd8192;
    k1[1]     = 16'd4096;
    k_half    = '0;
    k_half[0] = 16'd8192;

    vecs[0].name = "identity";   vecs[0].coef = k_id;
    vecs[0].win = mkwin(8'd77, 8'd200); vecs[0].win[0] = 8'd9; vecs[0].win[10] = 8'd9;
    vecs[0].exp = 8'd77;
    vecs[1].name = "k1 150";     vecs[1].coef = k1;
    vecs[1].win = mkwin(8'd200, 8'd100); vecs[1].exp = 8'd150;
    vecs[2].name = "saturate";   vecs[2].coef = {6{16'd16383}};
    vecs[2].win = {11{8'd255}};  vecs[2].exp = 8'd255;
    vecs[3].name = "round 1.5";  vecs[3].coef = k_half;
    vecs[3].win = mkwin(8'd3, 8'd50); vecs[3].exp = 8'd2;
    vecs[4].name = "round 0.5";  vecs[4].coef = k_half;
    vecs[4].win = mkwin(8'd1, 8'd50); vecs[4].exp = 8'd1;
    vecs[5].name = "outer taps"; vecs[5].coef = '0; vecs[5].coef[5] = 16'd16384;
    vecs[5].win = mkwin(8'd99, 8'd0); vecs[5].win[10] = 8'd10; vecs[5].win[0] = 8'd20;
    vecs[5].exp = 8'd30;
    vecs[6].name = "mixed";      vecs[6].coef = '0;
    vecs[6].coef[0] = 16'd4096; vecs[6].coef[1] = 16'd4096; vecs[6].coef[2] = 16'd2048;
    vecs[6].win = '0; vecs[6].win[5] = 8'd100; vecs[6].win[6] = 8'd40; vecs[6].win[4] = 8'd60;
    vecs[6].win[7] = 8'd8; vecs[6].win[3] = 8'd8; vecs[6].exp = 8'd52;
    vecs[7].name = "pair carry"; vecs[7].coef = '0; vecs[7].coef[1] = 16'd16384;
    vecs[7].win = '0; vecs[7].win[5] = 8'd7; vecs[7].win[6] = 8'd200; vecs[7].win[4] = 8'd100;
    vecs[7].exp = 8'd255;
    vecs[8].name = "half max";   vecs[8].coef = k_half;
    vecs[8].win = mkwin(8'd255, 8'd0); vecs[8].exp = 8'd128;

    do_reset();
    check("reset valid_out", 32'(bus.valid_out), 32'd0);
    check("reset data_out", 32'(bus.data_out), 32'd0);
    check("reset eol_out", 32'(bus.eol_out), 32'd0);
    check("reset border_out", 32'(bus.border_out), 32'd0);
    check("reset coef_busy", 32'(bus.coef_busy), 32'd0);

    // Single windows through an otherwise empty pipeline.
    for (int v = 0; v < 9; v++) begin
      load_coef(vecs[v].coef);
      check({vecs[v].name, " busy after idle load"}, 32'(bus.coef_busy), 32'd0);
      bus.data_in  = vecs[v].win;
      bus.valid_in = 1'b1;
      tick();
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      repeat (4) tick();
      check({vecs[v].name, " early valid"}, 32'(bus.valid_out), 32'd0);
      tick();
      check({vecs[v].name, " valid"}, 32'(bus.valid_out), 32'd1);
      check({vecs[v].name, " data"}, 32'(bus.data_out), 32'(vecs[v].exp));
      tick();
      check({vecs[v].name, " drained valid"}, 32'(bus.valid_out), 32'd0);
      check({vecs[v].name, " drained data"}, 32'(bus.data_out), 32'd0);
    end

    // Full line of flat 100 after reset (identity kernel).
    do_reset();
    mon_en = 1'b1;
    clear_tally();
    for (int i = 0; i < IC; i++) begin
      bus.data_in  = {11{8'd100}};
      exp_pix      = 8'd100;
      bus.valid_in = 1'b1;
      tick();
    end
    idle_inputs();
    repeat (10) tick();
    check("line outputs", 32'(out_cnt), 32'd512);
    check("line eol count", 32'(eol_cnt), 32'd1);
    check("line border count", 32'(border_cnt), 32'd10);

    // Kernel load mid-line: old kernel to line end, new one on the next line.
    for (int i = 0; i < IC; i++) begin
      bus.data_in   = mkwin(8'd200, 8'd100);
      exp_pix       = 8'd200;
      bus.valid_in  = 1'b1;
      bus.coef_load = (i == 100);
      bus.coef_in   = k1;
      tick();
      if (i == 100) check("busy after mid-line load", 32'(bus.coef_busy), 32'd1);
    end
    check("busy at line end", 32'(bus.coef_busy), 32'd1);
    idle_inputs();
    tick();
    check("busy while draining", 32'(bus.coef_busy), 32'd1);
    repeat (8) tick();
    check("busy cleared in gap", 32'(bus.coef_busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      bus.data_in  = mkwin(8'd200, 8'd100);
      exp_pix      = 8'd150;
      bus.valid_in = 1'b1;
      tick();
    end
    idle_inputs();
    repeat (10) tick();

    // valid_in drop at column 300 (k1 active: centre-only window -> (c+1)/2).
    clear_tally();
    for (int i = 0; i < 300 + 3 + IC; i++) begin
      c8           = 8'(i);
      bus.data_in  = mkwin(c8, 8'd0);
      exp_pix      = 8'((int'(c8) + 1) >> 1);
      bus.valid_in = !(i >= 300 && i < 303);
      tick();
    end
    idle_inputs();
    repeat (10) tick();
    check("drop outputs", 32'(out_cnt), 32'd812);
    check("drop eol count", 32'(eol_cnt), 32'd1);
    check("drop border count", 32'(border_cnt), 32'd15);

    // Reset mid-line, with a pending kernel load.
    for (int i = 0; i < 50; i++) begin
      bus.data_in   = mkwin(8'd60, 8'd40);
      exp_pix       = 8'd50;
      bus.valid_in  = 1'b1;
      bus.coef_load = (i == 10);
      bus.coef_in   = k_half;
      tick();
    end
    check("busy before reset", 32'(bus.coef_busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid reset valid_out", 32'(bus.valid_out), 32'd0);
    check("mid reset data_out", 32'(bus.data_out), 32'd0);
    check("mid reset eol_out", 32'(bus.eol_out), 32'd0);
    check("mid reset border_out", 32'(bus.border_out), 32'd0);
    check("mid reset coef_busy", 32'(bus.coef_busy), 32'd0);
    rst_n = 1'b1;
    idle_inputs();
    repeat (2) tick();
    for (int i = 0; i < 20; i++) begin
      bus.data_in  = mkwin(8'd123, 8'd100);
      exp_pix      = 8'd123;
      bus.valid_in = 1'b1;
      tick();
    end
    idle_inputs();
    repeat (10) tick();

    // Load coinciding with the promotion cycle: coef_in goes straight to active.
    bus.data_in  = mkwin(8'd80, 8'd100);
    exp_pix      = 8'd80;
    bus.valid_in = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    load_coef(k1);
    check("busy with window in flight", 32'(bus.coef_busy), 32'd1);
    repeat (5) tick();
    check("busy before idle cycle", 32'(bus.coef_busy), 32'd1);
    load_coef(k_half);
    check("busy after coincident load", 32'(bus.coef_busy), 32'd0);
    bus.data_in  = mkwin(8'd90, 8'd100);
    exp_pix      = 8'd45;
    bus.valid_in = 1'b1;
    tick();
    idle_inputs();
    repeat (10) tick();
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
